alu_muldiv_sequencer: RTL and testbench

Multi-cycle unsigned multiply/divide sequencer that reuses the shared 16-bit ALU instead of a dedicated multiplier. It sits beside the EX stage and drives the ALU operand and control inputs while busy. It produces a 32-bit product or a quotient/remainder in HI/LO registers in MIPS style. The pipeline stalls on `busy` and samples `hi`/`lo` on `done`.

---
 rtl/aura16_pkg.sv | 24 ++
 rtl/alu_muldiv_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_muldiv_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/aura16_pkg.sv
// Shared definitions for the aura16 EX stage: ALU opcodes, the mul/div
// sequencer op encoding and its state type.
package aura16_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  // ALU opcodes (3-bit alu_ctrl)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // Sequencer operation select
  localparam logic OP_MULU = 1'b0;
  localparam logic OP_DIVU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned MULU/DIVU sequencer that borrows the shared EX-stage
// ALU. One shift-add (MULU) or restoring-subtract (DIVU) step per RUN cycle;
// results land in HI/LO and are held until the next accepted start.
module alu_muldiv_sequencer
  import aura16_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  seq_state_e       state_q;
  logic [WIDTH-1:0] acc_q;   // product high half (MULU) / partial remainder (DIVU)
  logic [WIDTH-1:0] lo_q;    // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] b_q;     // multiplicand (MULU) / divisor (DIVU)
  logic [CW-1:0]    cnt_q;
  logic             op_q;
  logic             dbz_q;

  logic [WIDTH-1:0] sh;
  logic             ovf;
  logic             carry;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] lo_d;

  // One iteration of the active algorithm, using the ALU result for this cycle
  always_comb begin
    sh    = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
    ovf   = acc_q[WIDTH-1];
    carry = (alu_result < acc_q);
    if (op_q == OP_MULU) begin
      if (lo_q[0]) begin
        acc_d = {carry, alu_result[WIDTH-1:1]};
        lo_d  = {alu_result[0], lo_q[WIDTH-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[WIDTH-1:1]};
        lo_d  = {acc_q[0], lo_q[WIDTH-1:1]};
      end
    end else if (ovf || (sh >= b_q)) begin
      // ovf means the true shifted remainder has a 17th bit, so it always
      // exceeds the divisor and the wrapped ALU difference is exact.
      acc_d = alu_result;
      lo_d  = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = sh;
      lo_d  = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  // ALU operand/control decode from registered state only (no start/operand path)
  always_comb begin
    alu_ctrl = ALU_ADD;
    alu_a    = '0;
    alu_b    = '0;
    if (state_q == ST_RUN) begin
      alu_b = b_q;
      if (op_q == OP_MULU) begin
        alu_a = acc_q;
      end else begin
        alu_ctrl = ALU_SUB;
        alu_a    = sh;
      end
    end
  end

  // Sequencer FSM, iteration counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      op_q    <= OP_MULU;
      dbz_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op;
            cnt_q <= '0;
            if ((op == OP_DIVU) && (operand_b == '0)) begin
              acc_q   <= operand_a;
              lo_q    <= '1;
              b_q     <= '0;
              dbz_q   <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              acc_q   <= '0;
              lo_q    <= (op == OP_DIVU) ? operand_a : operand_b;
              b_q     <= (op == OP_DIVU) ? operand_b : operand_a;
              dbz_q   <= 1'b0;
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign hi          = acc_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Self-checking bench for alu_muldiv_sequencer with a behavioural EX-stage ALU.
module tb_alu_muldiv_sequencer;
  import aura16_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [15:0] operand_a, operand_b;
  logic        busy, done, div_by_zero;
  logic [15:0] hi, lo;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_muldiv_sequencer #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .busy       (busy),
    .done       (done),
    .hi         (hi),
    .lo         (lo),
    .div_by_zero(div_by_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result)
  );

  // Shared EX-stage ALU
  always_comb begin
    case (alu_ctrl)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_SLT: alu_result = {15'd0, alu_a < alu_b};
      default: alu_result = '0;
    endcase
  end

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the operation's definition
  task automatic ref_model(input logic o, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] ehi, output logic [15:0] elo, output logic edbz);
    logic [31:0] p;
    if (o == OP_MULU) begin
      p = 32'(a) * 32'(b);
      ehi = p[31:16]; elo = p[15:0]; edbz = 1'b0;
    end else if (b == 16'd0) begin
      ehi = a; elo = 16'hFFFF; edbz = 1'b1;
    end else begin
      ehi = a % b; elo = a / b; edbz = 1'b0;
    end
  endtask

  // Issue one operation and check latency, busy profile, results and retention
  task automatic apply(input string nm, input logic o, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] ehi, input logic [15:0] elo, input logic edbz);
    int lat;
    bit busy_bad;
    logic exp_busy;
    lat = 0;
    busy_bad = 1'b0;
    exp_busy = ~edbz;
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 1'($urandom_range(1));
    operand_a = 16'($urandom);
    operand_b = 16'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (busy !== exp_busy) busy_bad = 1'b1;
    end
    check({nm, ".latency"}, 32'(lat), edbz ? 32'd1 : 32'd17);
    check({nm, ".hi"}, 32'(hi), 32'(ehi));
    check({nm, ".lo"}, 32'(lo), 32'(elo));
    check({nm, ".dbz"}, 32'(div_by_zero), 32'(edbz));
    check({nm, ".busy_run"}, 32'(busy_bad), 32'd0);
    check({nm, ".busy_at_done"}, 32'(busy), 32'd0);
    check({nm, ".alu_idle"}, {13'd0, alu_ctrl, alu_a}, 32'd0);
    @(negedge clk);
    check({nm, ".done_pulse"}, 32'(done), 32'd0);
    check({nm, ".hold"}, {hi, lo}, {ehi, elo});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ehi, elo, ra, rb;
    logic        edbz, ro;
    int          ndone, first_done;
    logic [15:0] cap_hi, cap_lo;

    tbl[0] = '{1'b0, 16'd300,    16'd200,    16'h0000, 16'hEA60, 1'b0};
    tbl[1] = '{1'b0, 16'hFFFF,   16'hFFFF,   16'hFFFE, 16'h0001, 1'b0};
    tbl[2] = '{1'b1, 16'd1000,   16'd7,      16'h0006, 16'h008E, 1'b0};
    tbl[3] = '{1'b1, 16'hFFFF,   16'h8001,   16'h7FFE, 16'h0001, 1'b0};
    tbl[4] = '{1'b1, 16'h1234,   16'h0000,   16'h1234, 16'hFFFF, 1'b1};
    tbl[5] = '{1'b0, 16'h0000,   16'h1234,   16'h0000, 16'h0000, 1'b0};
    tbl[6] = '{1'b1, 16'd5,      16'd9,      16'h0005, 16'h0000, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
    #1;
    check("reset.outs", {27'd0, busy, done, div_by_zero, 2'd0}, 32'd0);
    check("reset.hilo", {hi, lo}, 32'd0);
    check("reset.alu", {alu_a, alu_b}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i])
      apply($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dbz);

    // start during RUN must be ignored, not queued
    ndone = 0; first_done = 0; cap_hi = '0; cap_lo = '0;
    @(negedge clk);
    start = 1'b1; op = OP_MULU; operand_a = 16'd300; operand_b = 16'd200;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5) begin
        start = 1'b1; op = OP_DIVU; operand_a = 16'd77; operand_b = 16'd3;
      end
      if (k == 6) start = 1'b0;
      if (done) begin
        ndone++;
        if (first_done == 0) begin
          first_done = k; cap_hi = hi; cap_lo = lo;
        end
      end
    end
    check("ignore.ndone", 32'(ndone), 32'd1);
    check("ignore.latency", 32'(first_done), 32'd17);
    check("ignore.result", {cap_hi, cap_lo}, {16'h0000, 16'hEA60});
    check("ignore.hold", {hi, lo}, {16'h0000, 16'hEA60});

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; op = OP_MULU; operand_a = 16'd300; operand_b = 16'd200;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.outs", {27'd0, busy, done, div_by_zero, 2'd0}, 32'd0);
    check("midrst.hilo", {hi, lo}, 32'd0);
    check("midrst.alu", {13'd0, alu_ctrl, alu_a}, 32'd0);
    check("midrst.alub", 32'(alu_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("postrst.mul3x5", OP_MULU, 16'd3, 16'd5, 16'd0, 16'd15, 1'b0);

    // randomized operations against the arithmetic reference
    for (int n = 0; n < 40; n++) begin
      ro = 1'($urandom_range(1));
      ra = 16'($urandom);
      rb = ($urandom_range(9) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(3) == 0) rb = rb >> $urandom_range(15);
      ref_model(ro, ra, rb, ehi, elo, edbz);
      apply($sformatf("rnd%0d", n), ro, ra, rb, ehi, elo, edbz);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
